// File: rtl/seq_stream_tx.sv
// Serial frame transmitter: each accepted word goes out as a 6-bit sync header
// followed by the DATA_W-bit payload, MSB first, optionally followed by idle gap cycles.
module seq_stream_tx #(
  parameter logic [5:0]  SYNC_A = 6'b111000,
  parameter logic [5:0]  SYNC_B = 6'b101110,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned GAP    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              hdr_sel,
  input  logic              data_in_vld,
  output logic              data_in_rdy,
  output logic              dout,
  output logic              dout_vld,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned HDR_W   = 6;
  localparam int unsigned FRAME_W = HDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + GAP + 1);
  localparam bit          HAS_GAP = (GAP != 0);

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(FRAME_W + GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               dout_q, dout_d;
  logic               vld_q, vld_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               data_last;
  logic               gap_last;
  logic               accept;
  logic [HDR_W-1:0]   hdr_word;

  // The counter tracks the position within header+payload+gap, so the
  // "last cycle" decodes below are simple compares against fixed positions.
  assign data_last   = (state_q == ST_DATA) && (cnt_q == DATA_LAST);
  assign gap_last    = (state_q == ST_GAP)  && (cnt_q == GAP_LAST);
  assign data_in_rdy = rst_n && ((state_q == ST_IDLE) ||
                                 (data_last && !HAS_GAP) ||
                                 gap_last);
  assign accept      = data_in_vld && data_in_rdy;
  assign hdr_word    = hdr_sel ? SYNC_B : SYNC_A;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
      end
      ST_HDR: begin
        cnt_d   = cnt_q + CNT_ONE;
        shift_d = shift_q << 1;
        if (cnt_q == HDR_LAST) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        shift_d = shift_q << 1;
        if (cnt_q == DATA_LAST) begin
          if (HAS_GAP) begin
            state_d = ST_GAP;
            cnt_d   = cnt_q + CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase

    // An accept can only land on a cycle that would otherwise return to IDLE,
    // so it simply overrides that choice and starts the next frame.
    if (accept) begin
      state_d = ST_HDR;
      cnt_d   = '0;
      shift_d = {hdr_word, data_in};
    end

    vld_d  = (state_d == ST_HDR) || (state_d == ST_DATA);
    dout_d = vld_d && shift_d[FRAME_W-1];
    done_d = (state_d == ST_DATA) && (cnt_d == DATA_LAST);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = vld_q;
  assign frame_done = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seq_stream_tx.sv
// Bench for seq_stream_tx: a GAP=0 and a GAP=3 instance share one stimulus stream
// and are checked every cycle against a frame-position model plus literal frame traces.
module tb_seq_stream_tx;

  localparam int DW = 8;
  localparam int FL = 6 + DW;
  localparam logic [5:0] SA = 6'b111000;
  localparam logic [5:0] SB = 6'b101110;

  localparam int F_VLD  = 0;
  localparam int F_DOUT = 1;
  localparam int F_DONE = 2;
  localparam int F_RDY  = 3;
  localparam int F_BUSY = 4;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] dataIn;
  logic          hdrSel;
  logic          dataInVld;
  logic [1:0]    rdy;
  logic [1:0]    dout;
  logic [1:0]    doutVld;
  logic [1:0]    frameDone;
  logic [1:0]    busy;

  int vectors = 0;
  int miscompares = 0;

  int            gapOf [2] = '{0, 3};
  int            mPos  [2] = '{-1, -1};
  logic [FL-1:0] mFrame[2] = '{'0, '0};

  logic [1:0] trVld [64];
  logic [1:0] trDout[64];
  logic [1:0] trDone[64];
  logic [1:0] trRdy [64];
  logic [1:0] trBusy[64];

  int   p;
  logic eVld, eDout, eDone, eBusy, eRdy;

  seq_stream_tx #(.DATA_W(DW), .GAP(0)) u_gap0 (
    .clk(clk), .rst_n(rst_n), .data_in(dataIn), .hdr_sel(hdrSel),
    .data_in_vld(dataInVld), .data_in_rdy(rdy[0]), .dout(dout[0]),
    .dout_vld(doutVld[0]), .frame_done(frameDone[0]), .busy(busy[0])
  );

  seq_stream_tx #(.DATA_W(DW), .GAP(3)) u_gap3 (
    .clk(clk), .rst_n(rst_n), .data_in(dataIn), .hdr_sel(hdrSel),
    .data_in_vld(dataInVld), .data_in_rdy(rdy[1]), .dout(dout[1]),
    .dout_vld(doutVld[1]), .frame_done(frameDone[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic sel, input logic vld);
    @(posedge clk);
    #2;
    dataIn    = d;
    hdrSel    = sel;
    dataInVld = vld;
  endtask

  task automatic captureTrace(input int n, input int dropAt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      trVld[i]  = doutVld;
      trDout[i] = dout;
      trDone[i] = frameDone;
      trRdy[i]  = rdy;
      trBusy[i] = busy;
      if (i == dropAt) begin
        @(posedge clk);
        #2;
        dataInVld = 1'b0;
      end
    end
  endtask

  function automatic logic [63:0] packTr(input int field, input int d, input int start, input int len);
    logic [63:0] r;
    logic        b;
    r = '0;
    for (int i = 0; i < len; i++) begin
      case (field)
        F_VLD:   b = trVld[start+i][d];
        F_DOUT:  b = trDout[start+i][d];
        F_DONE:  b = trDone[start+i][d];
        F_RDY:   b = trRdy[start+i][d];
        default: b = trBusy[start+i][d];
      endcase
      r = {r[62:0], b};
    end
    return r;
  endfunction

  // Model: each instance is either idle (position -1) or at a position within
  // header+payload+gap; a word is taken when idle or on the final frame position.
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mPos[d] <= -1;
      end else if (dataInVld && (mPos[d] < 0 || mPos[d] == FL - 1 + gapOf[d])) begin
        mPos[d]   <= 0;
        mFrame[d] <= {(hdrSel ? SB : SA), dataIn};
      end else if (mPos[d] == FL - 1 + gapOf[d]) begin
        mPos[d] <= -1;
      end else if (mPos[d] >= 0) begin
        mPos[d] <= mPos[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      p     = mPos[d];
      eVld  = (p >= 0) && (p < FL);
      eDout = 1'b0;
      if (eVld) eDout = mFrame[d][FL-1-p];
      eDone = (p == FL - 1);
      eBusy = (p >= 0);
      eRdy  = rst_n && ((p < 0) || (p == FL - 1 + gapOf[d]));
      checkOutput($sformatf("dut%0d_dout_vld", d), doutVld[d], eVld);
      checkOutput($sformatf("dut%0d_dout", d), dout[d], eDout);
      checkOutput($sformatf("dut%0d_frame_done", d), frameDone[d], eDone);
      checkOutput($sformatf("dut%0d_busy", d), busy[d], eBusy);
      checkOutput($sformatf("dut%0d_rdy", d), rdy[d], eRdy);
    end
  end

  initial begin
    rst_n     = 1'b0;
    dataIn    = 8'hA5;
    hdrSel    = 1'b0;
    dataInVld = 1'b1;

    // Reset held with a word offered: nothing may come out or be accepted.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rst%0d_vld", d), doutVld[d], 1'b0);
      checkOutput($sformatf("rst%0d_dout", d), dout[d], 1'b0);
      checkOutput($sformatf("rst%0d_rdy", d), rdy[d], 1'b0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rel%0d_rdy", d), rdy[d], 1'b1);
      checkOutput($sformatf("rel%0d_busy", d), busy[d], 1'b0);
    end

    // Single frame A5 with header A.
    @(posedge clk);
    #2;
    dataInVld = 1'b0;
    captureTrace(17, -1);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("a5_bits%0d", d), packTr(F_DOUT, d, 0, 14), 14'b111000_10100101);
      checkOutput($sformatf("a5_vld%0d", d), packTr(F_VLD, d, 0, 15), 15'b111111111111110);
      checkOutput($sformatf("a5_done%0d", d), packTr(F_DONE, d, 0, 15), 15'b000000000000010);
    end
    checkOutput("a5_busy_drop0", packTr(F_BUSY, 0, 13, 2), 2'b10);
    checkOutput("a5_gap_busy3", packTr(F_BUSY, 1, 13, 4), 4'b1111);

    // Header B with an all-zero payload.
    applyStimulus(8'h00, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b0);
    captureTrace(17, -1);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("hdrb_bits%0d", d), packTr(F_DOUT, d, 0, 14), 14'b101110_00000000);
    end

    // Back-to-back: FF then 3C, header select flipped while frame 1 is in flight.
    applyStimulus(8'hFF, 1'b0, 1'b1);
    applyStimulus(8'h3C, 1'b1, 1'b1);
    captureTrace(30, 13);
    checkOutput("b2b_bits0", packTr(F_DOUT, 0, 0, 28), {SA, 8'hFF, SB, 8'h3C});
    checkOutput("b2b_vld0", packTr(F_VLD, 0, 0, 29), 29'h1FFFFFFE);
    checkOutput("b2b_rdy0", packTr(F_RDY, 0, 0, 28), 28'h0004001);
    checkOutput("b2b_bits3", packTr(F_DOUT, 1, 0, 14), {SA, 8'hFF});
    checkOutput("b2b_rdy3", packTr(F_RDY, 1, 0, 17), 17'h00001);

    // Two queued words through the gapped instance.
    applyStimulus(8'h5A, 1'b0, 1'b1);
    applyStimulus(8'hC3, 1'b1, 1'b1);
    captureTrace(36, 16);
    checkOutput("gap_vld3", packTr(F_VLD, 1, 0, 36), 36'hFFFC7FFE0);
    checkOutput("gap_rdy3", packTr(F_RDY, 1, 0, 31), 31'h00004000);
    checkOutput("gap_f2_bits3", packTr(F_DOUT, 1, 17, 14), {SB, 8'hC3});
    checkOutput("gap_f2_bits0", packTr(F_DOUT, 0, 14, 14), {SB, 8'hC3});

    // Reset during payload bit 3, then a clean restart.
    applyStimulus(8'h08, 1'b0, 1'b1);
    applyStimulus(8'h08, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("mid%0d_bit3", d), {doutVld[d], dout[d]}, 2'b11);
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("midrst%0d_outs", d),
                  {doutVld[d], dout[d], frameDone[d], busy[d], rdy[d]}, 5'b00000);
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n     = 1'b1;
    dataIn    = 8'h81;
    hdrSel    = 1'b0;
    dataInVld = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("midrel%0d_rdy", d), {rdy[d], busy[d]}, 2'b10);
    end
    @(posedge clk);
    #2;
    dataInVld = 1'b0;
    captureTrace(14, -1);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("restart_bits%0d", d), packTr(F_DOUT, d, 0, 14), {SA, 8'h81});
    end

    // Random traffic with occasional asynchronous resets; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      dataIn    = DW'($urandom);
      hdrSel    = 1'($urandom);
      dataInVld = ($urandom_range(0, 9) < 7);
      if (!rst_n) begin
        if ($urandom_range(0, 3) == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
      end
    end
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    dataInVld = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
